// File: rtl/rv32_mem_pkg.sv
// Shared types for the instruction/data RAM port-B arbitration.
package rv32_mem_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    localparam int MAX_WAIT_DEFAULT = 4;
    localparam int WAIT_CNT_W       = 4;

endpackage

// File: rtl/dpram_portb_arb.sv
// Port-B arbiter: the host owns the port during BOOT; in RUN the core has priority
// and the host is guaranteed a grant after MAX_WAIT consecutive refusals.
//
// state | meaning
// ------+-----------------------------------------------------------
// BOOT  | program load, host only, core requests stall
// RUN   | core priority, host granted when core idle or wait saturated
module dpram_portb_arb
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int MAX_WAIT   = MAX_WAIT_DEFAULT,
    localparam int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
    input  logic                  clk,
    input  logic                  xreset,
    input  logic                  boot_done,

    input  logic                  cpu_req,
    input  logic [NUM_COL-1:0]    cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,

    input  logic                  host_req,
    input  logic [NUM_COL-1:0]    host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,

    output logic                  enaB,
    output logic [NUM_COL-1:0]    weB,
    output logic [ADDR_WIDTH-1:0] addrB,
    output logic [DATA_WIDTH-1:0] dinB,
    input  logic [DATA_WIDTH-1:0] doutB
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);

    arb_state_t            state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    owner_t                owner_q, owner_d;
    logic                  wait_at_max;

    assign wait_at_max = (wait_cnt_q == WAIT_LIMIT);

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            state_q    <= BOOT;
            wait_cnt_q <= '0;
            owner_q    <= OWN_NONE;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            owner_q    <= owner_d;
        end
    end

    // Grants are qualified by xreset so the RAM port stays idle while reset is held.
    always_comb begin
        state_d  = state_q;
        host_gnt = 1'b0;
        cpu_gnt  = 1'b0;
        if (xreset) begin
            if (state_q == BOOT) begin
                host_gnt = host_req;
                if (boot_done) begin
                    state_d = RUN;
                end
            end else begin
                host_gnt = host_req & (~cpu_req | wait_at_max);
                cpu_gnt  = cpu_req & ~host_gnt;
            end
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (state_q == RUN && host_req && !host_gnt) begin
            wait_cnt_d = wait_at_max ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
    end

    always_comb begin
        weB     = '0;
        addrB   = '0;
        dinB    = '0;
        owner_d = OWN_NONE;
        if (cpu_gnt) begin
            weB   = cpu_we;
            addrB = cpu_addr;
            dinB  = cpu_wdata;
            if (cpu_we == '0) begin
                owner_d = OWN_CPU;
            end
        end else if (host_gnt) begin
            weB   = host_we;
            addrB = host_addr;
            dinB  = host_wdata;
            if (host_we == '0) begin
                owner_d = OWN_HOST;
            end
        end
    end

    assign enaB        = cpu_gnt | host_gnt;
    assign cpu_stall   = cpu_req & ~cpu_gnt;
    assign cpu_rvalid  = (owner_q == OWN_CPU);
    assign host_rvalid = (owner_q == OWN_HOST);
    assign cpu_rdata   = doutB;
    assign host_rdata  = doutB;

endmodule

// File: tb/tb_dpram_portb_arb.sv
// Directed bench for dpram_portb_arb with a behavioural model checked every cycle.
module tb_dpram_portb_arb;

    localparam int AW = 13;
    localparam int NC = 4;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk;
    logic          xreset;
    logic          boot_done;
    logic          cpu_req, host_req;
    logic [NC-1:0] cpu_we, host_we;
    logic [AW-1:0] cpu_addr, host_addr;
    logic [DW-1:0] cpu_wdata, host_wdata;
    logic          cpu_gnt, cpu_stall, cpu_rvalid;
    logic          host_gnt, host_rvalid;
    logic [DW-1:0] cpu_rdata, host_rdata;
    logic          enaB;
    logic [NC-1:0] weB;
    logic [AW-1:0] addrB;
    logic [DW-1:0] dinB, doutB;

    int n_cmp  = 0;
    int n_fail = 0;

    dpram_portb_arb #(.ADDR_WIDTH(AW), .NUM_COL(NC), .COL_WIDTH(8), .MAX_WAIT(MW)) dut (
        .clk(clk), .xreset(xreset), .boot_done(boot_done),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .enaB(enaB), .weB(weB), .addrB(addrB), .dinB(dinB), .doutB(doutB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM port B: 1-cycle read latency, output held during writes.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        doutB = '0;
    end
    always @(posedge clk) begin
        if (enaB) begin
            if (weB != '0) begin
                for (int b = 0; b < NC; b++)
                    if (weB[b]) ram[addrB][b*8 +: 8] <= dinB[b*8 +: 8];
            end else begin
                doutB <= ram[addrB];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase flag, consecutive-refusal count, pending read, shadow memory.
    bit            m_run;
    int            m_refused;
    int            m_pend;
    logic [DW-1:0] m_pend_data;
    logic [DW-1:0] shadow [int];

    initial begin
        m_run = 0; m_refused = 0; m_pend = 0; m_pend_data = '0;
    end

    always @(negedge clk) begin
        bit            eh, ec;
        logic [NC-1:0] ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        int            owner;
        if (!xreset) begin
            check("rst_cpu_gnt", cpu_gnt, 0);
            check("rst_host_gnt", host_gnt, 0);
            check("rst_enaB", enaB, 0);
            check("rst_weB", weB, 0);
            check("rst_cpu_rvalid", cpu_rvalid, 0);
            check("rst_host_rvalid", host_rvalid, 0);
            m_run = 0; m_refused = 0; m_pend = 0;
        end else begin
            eh = host_req && (!m_run || !cpu_req || m_refused >= MW);
            ec = m_run && cpu_req && !eh;
            ewe = '0; ea = '0; ed = '0; owner = 0;
            if (ec) begin ewe = cpu_we; ea = cpu_addr; ed = cpu_wdata; owner = 1; end
            if (eh) begin ewe = host_we; ea = host_addr; ed = host_wdata; owner = 2; end
            check("host_gnt", host_gnt, eh);
            check("cpu_gnt", cpu_gnt, ec);
            check("cpu_stall", cpu_stall, cpu_req && !ec);
            check("enaB", enaB, ec || eh);
            check("weB", weB, ewe);
            check("addrB", addrB, ea);
            check("dinB", dinB, ed);
            check("cpu_rvalid", cpu_rvalid, m_pend == 1);
            check("host_rvalid", host_rvalid, m_pend == 2);
            if (m_pend == 1) check("cpu_rdata", cpu_rdata, m_pend_data);
            if (m_pend == 2) check("host_rdata", host_rdata, m_pend_data);
            // Advance model for the next cycle.
            m_pend = 0;
            if (owner != 0) begin
                if (ewe == '0) begin
                    m_pend = owner;
                    m_pend_data = shadow.exists(int'(ea)) ? shadow[int'(ea)] : '0;
                end else begin
                    logic [DW-1:0] w;
                    w = shadow.exists(int'(ea)) ? shadow[int'(ea)] : '0;
                    for (int b = 0; b < NC; b++)
                        if (ewe[b]) w[b*8 +: 8] = ed[b*8 +: 8];
                    shadow[int'(ea)] = w;
                end
            end
            if (m_run && host_req && !eh) m_refused = (m_refused + 1 > MW) ? MW : m_refused + 1;
            else m_refused = 0;
            if (boot_done) m_run = 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_set(input logic req, input logic [3:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic host_set(input logic req, input logic [3:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_req = req; host_we = we; host_addr = a; host_wdata = d;
    endtask

    initial begin
        int granted_at;
        xreset = 1'b0; boot_done = 1'b0;
        cpu_set(0, 0, 0, 0);
        host_set(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 xreset = 1'b1;

        // BOOT: host write while core requests
        step();
        cpu_set(1, 4'h0, 13'h010, 0);
        host_set(1, 4'hF, 13'h010, 32'hDEADBEEF);
        @(negedge clk);
        check("boot_host_gnt", host_gnt, 1);
        check("boot_cpu_stall", cpu_stall, 1);
        step();
        host_set(1, 4'h0, 13'h010, 0);
        @(negedge clk);
        check("boot_rd_gnt", host_gnt, 1);
        step();
        host_set(0, 0, 0, 0);
        @(negedge clk);
        check("boot_rd_rvalid", host_rvalid, 1);
        check("boot_rd_data", host_rdata, 32'hDEADBEEF);

        // boot_done with a host request, then a core read
        step();
        cpu_set(0, 0, 0, 0);
        host_set(1, 4'hF, 13'h020, 32'h12345678);
        boot_done = 1'b1;
        @(negedge clk);
        check("bd_host_gnt", host_gnt, 1);
        step();
        boot_done = 1'b0;
        host_set(0, 0, 0, 0);
        cpu_set(1, 4'h0, 13'h010, 0);
        @(negedge clk);
        check("run_cpu_gnt", cpu_gnt, 1);
        step();
        cpu_set(0, 0, 0, 0);
        @(negedge clk);
        check("run_cpu_rvalid", cpu_rvalid, 1);
        check("run_cpu_rdata", cpu_rdata, 32'hDEADBEEF);

        // Bounded host wait under continuous core traffic
        step();
        cpu_set(1, 4'h0, 13'h020, 0);
        host_set(1, 4'h0, 13'h010, 0);
        granted_at = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (host_gnt) begin
                granted_at = i;
                check("wait_cpu_stall", cpu_stall, 1);
                break;
            end
            step();
        end
        check("wait_refusals", granted_at, MW);
        step();
        host_set(0, 0, 0, 0);
        @(negedge clk);
        check("wait_host_rvalid", host_rvalid, 1);
        check("wait_host_rdata", host_rdata, 32'hDEADBEEF);
        step();
        host_set(1, 4'h0, 13'h010, 0);
        @(negedge clk);
        check("wait_cleared", host_gnt, 0);
        step();
        host_set(0, 0, 0, 0);
        cpu_set(0, 0, 0, 0);

        // Core byte write then read back
        step();
        cpu_set(1, 4'b0100, 13'h010, 32'h00AB0000);
        @(negedge clk);
        check("bw_cpu_gnt", cpu_gnt, 1);
        step();
        cpu_set(1, 4'h0, 13'h010, 0);
        step();
        cpu_set(0, 0, 0, 0);
        @(negedge clk);
        check("bw_rvalid", cpu_rvalid, 1);
        check("bw_rdata", cpu_rdata, 32'hDEABBEEF);

        // Alternating owners, back-to-back reads
        step();
        cpu_set(1, 4'h0, 13'h010, 0);
        step();
        cpu_set(0, 0, 0, 0);
        host_set(1, 4'h0, 13'h020, 0);
        @(negedge clk);
        check("alt_cpu_rvalid", cpu_rvalid, 1);
        check("alt_cpu_rdata", cpu_rdata, 32'hDEABBEEF);
        check("alt_host_rvalid0", host_rvalid, 0);
        step();
        host_set(0, 0, 0, 0);
        cpu_set(1, 4'h0, 13'h020, 0);
        @(negedge clk);
        check("alt_host_rvalid", host_rvalid, 1);
        check("alt_host_rdata", host_rdata, 32'h12345678);
        check("alt_cpu_rvalid0", cpu_rvalid, 0);
        step();
        cpu_set(0, 0, 0, 0);
        @(negedge clk);
        check("alt_cpu_rvalid2", cpu_rvalid, 1);
        check("alt_cpu_rdata2", cpu_rdata, 32'h12345678);

        // Reset in the cycle after a core read grant
        step();
        cpu_set(1, 4'h0, 13'h010, 0);
        @(negedge clk);
        check("rst_rd_gnt", cpu_gnt, 1);
        step();
        cpu_set(0, 0, 0, 0);
        host_set(1, 4'h0, 13'h030, 0);
        xreset = 1'b0;
        @(negedge clk);
        check("rst_no_rvalid", cpu_rvalid, 0);
        check("rst_enaB_held", enaB, 0);
        step();
        xreset = 1'b1;
        host_set(0, 0, 0, 0);
        cpu_set(1, 4'h0, 13'h010, 0);
        @(negedge clk);
        check("post_rst_boot_stall", cpu_stall, 1);
        check("post_rst_rvalid", cpu_rvalid, 0);
        step();
        cpu_set(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
